platform_scroller: RTL

PLATFORM_SCROLLER -- requirements
Module: platform_scroller

---
 rtl/platform_scroller.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/platform_scroller.sv
// Platform scroller: once per video frame, moves each of 16 platforms up the
// screen by SPEED pixels. A platform that reaches the top is respawned at the
// bottom with a pseudo-random x position and length. The new table is built
// in a working copy and published in a single cycle, so the drawing logic
// never sees a half-updated frame.
module platform_scroller #(
  parameter int unsigned SPEED = 2,
  parameter logic [15:0] SEED  = 16'hACE1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             vsync,
  input  logic             pause,
  output logic [15:0][28:0] info_ground,
  output logic             busy,
  output logic [7:0]       missed_frames
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] UPDATE = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;

  localparam logic [9:0] Y_LIMIT = 10'(SPEED + 2);
  localparam logic [8:0] Y_STEP  = 9'(SPEED);
  localparam logic [8:0] Y_SPAWN = 9'd477;

  logic [1:0]        state;
  logic [3:0]        idx;
  logic [15:0]       lfsr;
  logic              lfsr_fb;
  logic              vs_meta;
  logic              vs_sync;
  logic              vs_prev;
  logic              live;
  logic              armed;
  logic              tick;
  logic [15:0][28:0] work;
  logic [28:0]       cur;
  logic [28:0]       nxt;
  logic              respawn;

  // Power-on layout: platforms staggered down and across the screen.
  function automatic logic [28:0] reset_entry(input logic [3:0] i);
    logic [9:0] x;
    logic [8:0] y;
    x = {1'b0, i, 5'd0};
    y = ({5'd0, i} * 9'd30) + 9'd15;
    return {10'd96, y, x};
  endfunction

  // Synchronize vsync and only arm the edge detector once a real low level
  // has been sampled after reset, so a vsync that is already high at release
  // cannot masquerade as a new frame.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      vs_meta <= 1'b0;
      vs_sync <= 1'b0;
      vs_prev <= 1'b0;
      live    <= 1'b0;
      armed   <= 1'b0;
    end else begin
      vs_meta <= vsync;
      vs_sync <= vs_meta;
      vs_prev <= vs_sync;
      live    <= 1'b1;
      if (live && !vs_meta) armed <= 1'b1;
    end
  end

  assign tick    = vs_sync & ~vs_prev & armed;
  assign busy    = (state == UPDATE) || (state == COMMIT);
  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  // Frame sequencer: idle until a tick, walk all 16 entries, then publish.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      idx   <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          idx <= 4'd0;
          if (tick && !pause) state <= UPDATE;
        end
        UPDATE: begin
          idx <= idx + 4'd1;
          if (idx == 4'd15) state <= COMMIT;
        end
        COMMIT: begin
          idx   <= 4'd0;
          state <= IDLE;
        end
        default: begin
          idx   <= 4'd0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Count frames that arrived while the previous one was still being built.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      missed_frames <= 8'd0;
    end else if (tick && !pause && busy && (missed_frames != 8'hFF)) begin
      missed_frames <= missed_frames + 8'd1;
    end
  end

  // Next value of the entry under the index: scroll up, or respawn near the
  // bottom using the current LFSR bits (x <= 511, length <= 127 keeps the
  // platform on a 640-pixel line).
  always_comb begin
    cur     = work[idx];
    respawn = ({1'b0, cur[18:10]} <= Y_LIMIT);
    nxt     = cur;
    if (respawn) begin
      nxt = {10'd64 + {4'd0, lfsr[15:10]}, Y_SPAWN, {1'b0, lfsr[8:0]}};
    end else begin
      nxt[18:10] = cur[18:10] - Y_STEP;
    end
  end

  // Working copy is rewritten one entry per UPDATE cycle; the LFSR steps only
  // when an entry it fed is actually written.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      lfsr <= SEED;
      for (int i = 0; i < 16; i++) work[i] <= reset_entry(4'(i));
    end else if (state == UPDATE) begin
      work[idx] <= nxt;
      if (respawn) lfsr <= {lfsr[14:0], lfsr_fb};
    end
  end

  // Published table changes only on the COMMIT edge.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < 16; i++) info_ground[i] <= reset_entry(4'(i));
    end else if (state == COMMIT) begin
      info_ground <= work;
    end
  end

endmodule
